// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bus between an initiator and data_mem_responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding 64-bit word memory with fixed response latency.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q;
    logic [63:0]   addr_q, wdata_q;
    logic [63:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          accept, enter_resp, cur_write, cur_err;
    logic [63:0]   cur_addr, cur_wdata;
    logic [AW-1:0] idx;
    logic [63:0]   mem_q [DEPTH_WORDS] = '{default: '0};
    assign accept = bus.req_valid && state_q == IDLE;
    // With zero latency the commit happens on the accept edge, so the live bus stands in for the captured request
    assign cur_write = state_q == IDLE ? bus.req_write : write_q;
    assign cur_addr  = state_q == IDLE ? bus.req_addr  : addr_q;
    assign cur_wdata = state_q == IDLE ? bus.req_wdata : wdata_q;
    assign cur_err   = cur_addr[2:0] != 3'd0 || cur_addr >= (64'(DEPTH_WORDS) << 3);
    assign idx       = cur_addr[AW+2:3];
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                if (LATENCY == 0) enter_resp = 1'b1;
                else begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY);
                end
            end
            WAIT: if (cnt_q == 4'd1) enter_resp = 1'b1;
                  else cnt_d = cnt_q - 4'd1;
            RESP: if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            state_d = RESP;
            cnt_d   = 4'd0;
        end
        rdata_d = !cur_write && !cur_err ? mem_q[idx] : 64'd0;
        err_d   = cur_err;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (enter_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end
    // Storage survives reset; only the commit is suppressed by it
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && cur_write && !cur_err) mem_q[idx] <= cur_wdata;
    end
    assign bus.req_ready  = state_q == IDLE;
    assign bus.resp_valid = state_q == RESP;
    assign bus.resp_rdata = state_q == RESP ? rdata_q : 64'd0;
    assign bus.resp_err   = state_q == RESP && err_q;
endmodule
